// File: rtl/sram_pkg.sv
// Shared constants and helpers for the sram_1rw1r_wmask memory model.
package sram_pkg;

  localparam int LANE_WIDTH = 8;

  function automatic int lanes(input int width);
    return width / LANE_WIDTH;
  endfunction

endpackage

// File: rtl/sram_out_pipe.sv
// Optional output stage for one read-port output group.
// SRAM_OUT_REG_EN defined: reset-to-zero register; undefined: combinational pass-through.
module sram_out_pipe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

`ifdef SRAM_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign q = d;
`endif

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// 1RW+1R single-clock SRAM model with byte write mask, read-before-write on
// port collisions and read-valid strobes. SRAM_OUT_REG_EN adds an output stage.
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  localparam int WMASK_WIDTH = lanes(DATA_WIDTH)
) (
  input  logic                   clk0,
  input  logic                   rst_n,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dout0_valid,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   collision
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_width
    $error("sram_1rw1r_wmask: DATA_WIDTH must be a multiple of 8");
  end

  typedef struct packed {
    logic                   csb;
    logic                   web;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  din;
  } sram_req_t;

  localparam sram_req_t REQ_IDLE = '{csb: 1'b1, web: 1'b1, wmask: '0, addr: '0, din: '0};

  sram_req_t             req0;
  logic                  req1_csb;
  logic [ADDR_WIDTH-1:0] req1_addr;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  rd0, wr0, rd1;
  logic [DATA_WIDTH-1:0] dout0_s, dout1_s;
  logic                  dout0_valid_s, dout1_valid_s, collision_s;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      req0      <= REQ_IDLE;
      req1_csb  <= 1'b1;
      req1_addr <= '0;
    end else begin
      req0      <= '{csb: csb0, web: web0, wmask: wmask0, addr: addr0, din: din0};
      req1_csb  <= csb1;
      req1_addr <= addr1;
    end
  end

  always_comb begin
    rd0 = !req0.csb && req0.web;
    wr0 = !req0.csb && !req0.web;
    rd1 = !req1_csb;
  end

  // Array is deliberately unreset; a reset clears req0 so a captured write never lands.
  always_ff @(posedge clk0) begin
    if (wr0) begin
      for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
        if (req0.wmask[i]) begin
          mem[req0.addr][i*LANE_WIDTH +: LANE_WIDTH] <= req0.din[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Reads sample the array before this edge's write, giving read-before-write.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      dout0_s       <= '0;
      dout1_s       <= '0;
      dout0_valid_s <= 1'b0;
      dout1_valid_s <= 1'b0;
      collision_s   <= 1'b0;
    end else begin
      if (rd0) begin
        dout0_s <= mem[req0.addr];
      end
      if (rd1) begin
        dout1_s <= mem[req1_addr];
      end
      dout0_valid_s <= rd0;
      dout1_valid_s <= rd1;
      collision_s   <= rd1 && wr0 && (req1_addr == req0.addr);
    end
  end

  sram_out_pipe #(.WIDTH(DATA_WIDTH + 1)) u_pipe0 (
    .clk   (clk0),
    .rst_n (rst_n),
    .d     ({dout0_s, dout0_valid_s}),
    .q     ({dout0, dout0_valid})
  );

  sram_out_pipe #(.WIDTH(DATA_WIDTH + 2)) u_pipe1 (
    .clk   (clk0),
    .rst_n (rst_n),
    .d     ({dout1_s, dout1_valid_s, collision_s}),
    .q     ({dout1, dout1_valid, collision})
  );

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Directed bench for sram_1rw1r_wmask with a request-ordered memory model.
// Honours SRAM_OUT_REG_EN for the expected read latency.
module tb_sram_1rw1r_wmask;

`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int HIST = 2048;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;
  logic        dout0_valid, dout1_valid, collision;

  sram_1rw1r_wmask #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk0        (clk0),
    .rst_n       (rst_n),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0),
    .dout0_valid (dout0_valid),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid),
    .collision   (collision)
  );

  always #5 clk0 = ~clk0;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  // Model: a read sees every write requested in an earlier cycle; the write of
  // a request is committed when the next request is taken, or dropped by reset.
  logic [31:0] mmem [256];
  bit          pw_en = 1'b0;
  logic [7:0]  pw_addr;
  logic [31:0] pw_din;
  logic [3:0]  pw_mask;
  logic [31:0] m_d0 = '0, m_d1 = '0;

  bit          ev   [HIST];
  logic [31:0] ed0  [HIST];
  logic [31:0] ed1  [HIST];
  bit          ev0  [HIST];
  bit          ev1  [HIST];
  bit          ecol [HIST];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk0) begin
    edges = edges + 1;
    #1;
    if (rst_n && edges < HIST && ev[edges]) begin
      chk("dout0",       dout0,       ed0[edges]);
      chk("dout0_valid", {31'd0, dout0_valid}, {31'd0, ev0[edges]});
      chk("dout1",       dout1,       ed1[edges]);
      chk("dout1_valid", {31'd0, dout1_valid}, {31'd0, ev1[edges]});
      chk("collision",   {31'd0, collision},   {31'd0, ecol[edges]});
    end
  end

  task automatic step(input logic c0, input logic w0, input logic [3:0] m0,
                      input logic [7:0] a0, input logic [31:0] d0,
                      input logic c1, input logic [7:0] a1);
    bit rd0, wr0, rd1;
    int due;
    @(negedge clk0);
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0;
    csb1 = c1; addr1 = a1;
    if (pw_en) begin
      for (int i = 0; i < 4; i++)
        if (pw_mask[i]) mmem[pw_addr][8*i +: 8] = pw_din[8*i +: 8];
      pw_en = 1'b0;
    end
    rd0 = !c0 && w0;
    wr0 = !c0 && !w0;
    rd1 = !c1;
    if (rd0) m_d0 = mmem[a0];
    if (rd1) m_d1 = mmem[a1];
    due = edges + LAT;
    if (due < HIST) begin
      ev[due]   = 1'b1;
      ed0[due]  = m_d0;
      ed1[due]  = m_d1;
      ev0[due]  = rd0;
      ev1[due]  = rd1;
      ecol[due] = rd1 && wr0 && (a0 == a1);
    end
    if (wr0) begin
      pw_en = 1'b1; pw_addr = a0; pw_din = d0; pw_mask = m0;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    step(1'b0, 1'b0, m, a, d, 1'b1, 8'h00);
  endtask

  task automatic rdp0(input logic [7:0] a);
    step(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b1, 8'h00);
  endtask

  task automatic rdp1(input logic [7:0] a);
    step(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, a);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout0"}, dout0, 32'h0);
    chk({tag, "_dout1"}, dout1, 32'h0);
    chk({tag, "_v0"},   {31'd0, dout0_valid}, 32'h0);
    chk({tag, "_v1"},   {31'd0, dout1_valid}, 32'h0);
    chk({tag, "_col"},  {31'd0, collision},   32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    rst_n = 1'b0;
    pw_en = 1'b0;
    m_d0 = '0;
    m_d1 = '0;
    for (int e = edges + 1; e < HIST; e++) ev[e] = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    repeat (2) @(negedge clk0);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      idle();
      chk_reset_outputs("idle");
    end

    // Full write then port 0 read on the next cycle.
    wr(8'h05, 32'hAABBCCDD, 4'b1111);
    rdp0(8'h05);
    idles(LAT);
    chk("s1_dout0", dout0, 32'hAABBCCDD);
    chk("s1_v0", {31'd0, dout0_valid}, 32'h1);
    idle();
    chk("s1_v0_drop", {31'd0, dout0_valid}, 32'h0);
    chk("s1_hold", dout0, 32'hAABBCCDD);

    // Partial lane write then port 1 read.
    wr(8'h05, 32'h11223344, 4'b0101);
    rdp1(8'h05);
    idles(LAT);
    chk("s2_dout1", dout1, 32'hAA22CC44);
    chk("s2_v1", {31'd0, dout1_valid}, 32'h1);
    chk("s2_col", {31'd0, collision}, 32'h0);

    // Empty mask writes nothing.
    wr(8'h05, 32'hFFFFFFFF, 4'b0000);
    rdp0(8'h05);
    idles(LAT);
    chk("m0_dout0", dout0, 32'hAA22CC44);

    // Same-address collision: old data, then new data.
    wr(8'h10, 32'hDEADBEEF, 4'b1111);
    idle();
    step(1'b0, 1'b0, 4'b1111, 8'h10, 32'h01020304, 1'b0, 8'h10);
    rdp1(8'h10);
    idles(LAT - 1);
    chk("s3_old", dout1, 32'hDEADBEEF);
    chk("s3_col", {31'd0, collision}, 32'h1);
    idle();
    chk("s3_new", dout1, 32'h01020304);
    chk("s3_col_clr", {31'd0, collision}, 32'h0);

    // Back-to-back burst on both ports.
    for (int i = 0; i < 8; i++)
      wr(8'h40 + 8'(i), 32'h10000000 + 32'(i) * 32'h00010101, 4'b1111);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 4'h0, 8'h40 + 8'(i), 32'h0, 1'b0, 8'h47 - 8'(i));
    idles(LAT + 1);

    // Address extremes.
    wr(8'h00, 32'h0BADF00D, 4'b1111);
    wr(8'hFF, 32'h12345678, 4'b1111);
    step(1'b0, 1'b1, 4'h0, 8'hFF, 32'h0, 1'b0, 8'h00);
    idles(LAT);
    chk("edge_dout0", dout0, 32'h12345678);
    chk("edge_dout1", dout1, 32'h0BADF00D);

    // Reset right after a write is captured discards that write.
    wr(8'h20, 32'hCAFEF00D, 4'b1111);
    idle();
    wr(8'h20, 32'h55555555, 4'b1111);
    apply_reset();
    chk_reset_outputs("postrst");
    step(1'b0, 1'b1, 4'h0, 8'h20, 32'h0, 1'b0, 8'h20);
    idles(LAT);
    chk("rst_dout0", dout0, 32'hCAFEF00D);
    chk("rst_dout1", dout1, 32'hCAFEF00D);

    idles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
